// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
//
// Shared definitions for the exception/interrupt arbiter:
//   - exc_state_e : arbiter FSM states (IDLE -> ENTER -> HANDLER)
//   - EXC_*       : exception cause codes reported on exc_code
//   - N_INT_MAX   : largest supported number of hardware interrupt lines
// -----------------------------------------------------------------------------
package exc_pkg;

    // Arbiter FSM states.
    //   ST_IDLE    : normal execution, interrupts and sync exceptions accepted
    //   ST_ENTER   : one-cycle state in which EPC / cause are saved
    //   ST_HANDLER : handler running, only sync exceptions may re-enter
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2
    } exc_state_e;

    // Exception cause codes.
    localparam logic [4:0] EXC_INT = 5'd0;   // hardware interrupt
    localparam logic [4:0] EXC_SC  = 5'd8;   // system call
    localparam logic [4:0] EXC_BP  = 5'd9;   // breakpoint

    localparam int unsigned N_INT_MAX = 16;

endpackage : exc_pkg

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
//
// Fixed-priority encoder: the highest-index asserted request wins.
//
// Parameters
//   N_INT : number of request lines
//   ID_W  : width of the encoded index
//
// Ports
//   req_i : request vector
//   any_o : at least one request asserted
//   id_o  : index of the highest asserted request (0 when none asserted)
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int unsigned N_INT = 6,
    parameter int unsigned ID_W  = 4
) (
    input  logic [N_INT-1:0] req_i,
    output logic             any_o,
    output logic [ID_W-1:0]  id_o
);

    assign any_o = |req_i;

    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        id_o = '0;
        for (int unsigned i = 0; i < N_INT; i++) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule : prio_enc

// File: rtl/exc_arb.sv
// -----------------------------------------------------------------------------
// exc_arb
//
// Exception / interrupt arbiter sitting beside the main CPU FSM. It latches
// interrupt lines into a pending vector, qualifies them with the per-line mask
// and the global enable, and at an instruction boundary decides whether the
// CPU must branch to the exception entry instead of fetching.
//
// Parameters
//   N_INT     : number of hardware interrupt lines (1..16)
//   EDGE_MASK : per-line trigger type, 1 = edge, 0 = level
//   ID_W      : width of int_id (>= clog2(N_INT))
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   hw_int     : raw interrupt lines, synchronous to clk
//   int_mask   : per-line enable
//   int_en     : global interrupt enable
//   boundary   : main FSM is at an instruction-completion state
//   sync_req   : synchronous exception request (only meaningful with boundary)
//   sync_code  : cause code for sync_req
//   eret       : return-from-exception strobe
//   pend_clr   : write-1-to-clear for edge pending bits
//   take       : combinational, branch to the exception state instead of Fetch
//   exc_enter  : one-cycle pulse, save EPC and cause
//   exc_code   : registered cause code
//   int_id     : registered winning interrupt index
//   pending    : current pending vector
//   in_handler : high while the handler is running
// -----------------------------------------------------------------------------
module exc_arb
    import exc_pkg::*;
#(
    parameter int unsigned      N_INT     = 6,
    parameter logic [N_INT-1:0] EDGE_MASK = '0,
    parameter int unsigned      ID_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_INT-1:0] hw_int,
    input  logic [N_INT-1:0] int_mask,
    input  logic             int_en,
    input  logic             boundary,
    input  logic             sync_req,
    input  logic [4:0]       sync_code,
    input  logic             eret,
    input  logic [N_INT-1:0] pend_clr,
    output logic             take,
    output logic             exc_enter,
    output logic [4:0]       exc_code,
    output logic [ID_W-1:0]  int_id,
    output logic [N_INT-1:0] pending,
    output logic             in_handler
);

    // -------------------------------------------------------------------------
    // Pending vector
    // -------------------------------------------------------------------------
    logic [N_INT-1:0] prev_q;
    logic [N_INT-1:0] edge_pend_q;
    logic [N_INT-1:0] edge_pend_d;
    logic [N_INT-1:0] rise;
    logic [N_INT-1:0] pending_w;

    // prev_q resets to 0, so a line already high at reset release is seen
    // as a rising edge on the first cycle out of reset.
    assign rise = hw_int & ~prev_q & EDGE_MASK;

    // Set has priority over a same-cycle clear. Level lines never hold state
    // here, which also makes pend_clr a no-op for them.
    assign edge_pend_d = ((edge_pend_q & ~pend_clr) | rise) & EDGE_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            edge_pend_q <= '0;
        end else begin
            prev_q      <= hw_int;
            edge_pend_q <= edge_pend_d;
        end
    end

    // Level lines track the raw input directly; edge lines come from the latch.
    assign pending_w = (hw_int & ~EDGE_MASK) | edge_pend_q;
    assign pending   = pending_w;

    // -------------------------------------------------------------------------
    // Qualification and arbitration
    // -------------------------------------------------------------------------
    logic [N_INT-1:0] qual;
    logic             qual_any;
    logic [ID_W-1:0]  win_id;

    assign qual = pending_w & int_mask & {N_INT{int_en}};

    prio_enc #(
        .N_INT (N_INT),
        .ID_W  (ID_W)
    ) u_prio (
        .req_i (qual),
        .any_o (qual_any),
        .id_o  (win_id)
    );

    // -------------------------------------------------------------------------
    // Take decision
    // -------------------------------------------------------------------------
    exc_state_e state_q;
    logic       take_w;

    // Interrupts are accepted only from IDLE (no nesting); sync exceptions are
    // accepted from IDLE and HANDLER. Nothing is accepted during ENTER.
    always_comb begin
        take_w = 1'b0;
        if (boundary) begin
            unique case (state_q)
                ST_IDLE:    take_w = sync_req | qual_any;
                ST_HANDLER: take_w = sync_req;
                default:    take_w = 1'b0;
            endcase
        end
    end

    assign take = take_w;

    // -------------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // -------------------------------------------------------------------------
    logic            exc_enter_q;
    logic            in_handler_q;
    logic [4:0]      exc_code_q;
    logic [ID_W-1:0] int_id_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            exc_enter_q  <= 1'b0;
            in_handler_q <= 1'b0;
            exc_code_q   <= EXC_INT;
            int_id_q     <= '0;
        end else begin
            exc_enter_q <= 1'b0;
            if (take_w) begin
                // take has priority over eret in HANDLER: the return is dropped.
                state_q      <= ST_ENTER;
                exc_enter_q  <= 1'b1;
                in_handler_q <= 1'b0;
                if (sync_req) begin
                    exc_code_q <= sync_code;
                end else begin
                    exc_code_q <= EXC_INT;
                    int_id_q   <= win_id;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ENTER: begin
                        state_q      <= ST_HANDLER;
                        in_handler_q <= 1'b1;
                    end
                    ST_HANDLER: begin
                        if (eret) begin
                            state_q      <= ST_IDLE;
                            in_handler_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        in_handler_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign exc_enter  = exc_enter_q;
    assign in_handler = in_handler_q;
    assign exc_code   = exc_code_q;
    assign int_id     = int_id_q;

endmodule : exc_arb

// File: doc/exc_arb.md
EXC_ARB -- requirements
Module: exc_arb

Interface
REQ-001 The block SHALL have parameter N_INT, default 6: number of hardware interrupt lines, legal range 1..16.
REQ-002 The block SHALL have parameter EDGE_MASK, default all-zero, N_INT bits: bit i=1 makes line i edge-triggered, 0 makes it level-triggered.
REQ-003 The block SHALL have parameter ID_W, default 4: width of int_id, at least clog2(N_INT).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port hw_int, input, N_INT bits: raw interrupt lines, synchronous to clk.
REQ-007 The block SHALL have port int_mask, input, N_INT bits: per-line enable.
REQ-008 The block SHALL have port int_en, input, 1 bit: global interrupt enable.
REQ-009 The block SHALL have port boundary, input, 1 bit: the main FSM is in an instruction-completion state this cycle.
REQ-010 The block SHALL have port sync_req, input, 1 bit: synchronous exception request (break, syscall, ...), valid only with boundary.
REQ-011 The block SHALL have port sync_code, input, 5 bits: exception code for sync_req.
REQ-012 The block SHALL have port eret, input, 1 bit: return-from-exception strobe.
REQ-013 The block SHALL have port pend_clr, input, N_INT bits: write-1-to-clear for edge pending bits.
REQ-014 The block SHALL have port take, output, 1 bit: combinational; the main FSM SHALL branch to the exception state instead of Fetch.
REQ-015 The block SHALL have port exc_enter, output, 1 bit: one-cycle pulse to save EPC and cause.
REQ-016 The block SHALL have port exc_code, output, 5 bits: registered cause code.
REQ-017 The block SHALL have port int_id, output, ID_W bits: registered winning line index.
REQ-018 The block SHALL have port pending, output, N_INT bits: current pending vector.
REQ-019 The block SHALL have port in_handler, output, 1 bit: 1 while in state HANDLER.

Function
REQ-020 For edge lines, pending[i] SHALL be set on a registered rising edge (hw_int[i]=1, prev[i]=0).
REQ-021 An edge pending bit SHALL be cleared only by pend_clr[i]; if set and clear occur in the same cycle, set SHALL win.
REQ-022 For level lines, pending[i] SHALL equal hw_int[i] and pend_clr[i] SHALL be ignored.
REQ-023 The qualified interrupt vector SHALL be pending & int_mask & {N_INT{int_en}}.
REQ-024 Among qualified lines, the highest index SHALL win.
REQ-025 The FSM SHALL have states IDLE, ENTER and HANDLER.
REQ-026 take SHALL be 1 when boundary=1 and either (state=IDLE and (sync_req or any qualified)) or (state=HANDLER and sync_req); otherwise take SHALL be 0.
REQ-027 When take=1, the next state SHALL be ENTER.
REQ-028 When take=1, exc_code SHALL be registered as sync_code if sync_req=1, else 5'd0.
REQ-029 When take=1 for an interrupt, int_id SHALL be registered as the winner; it SHALL be unchanged for a sync exception.
REQ-030 sync_req SHALL have priority over any qualified interrupt in the same cycle.
REQ-031 In ENTER, exc_enter SHALL be 1 for exactly one cycle, and the next state SHALL be HANDLER.
REQ-032 In HANDLER, interrupts SHALL NOT be taken (no nesting).
REQ-033 A sync exception taken in HANDLER SHALL re-enter via ENTER, overwriting exc_code.
REQ-034 eret=1 in HANDLER SHALL move the FSM to IDLE on the next cycle; eret in IDLE or ENTER SHALL be ignored.
REQ-035 If eret and sync_req with boundary occur in the same cycle in HANDLER, sync SHALL win and eret SHALL be dropped.
REQ-036 Pending bits SHALL keep latching in every state.
REQ-037 Latency from a qualified edge on hw_int to possible take SHALL be 1 cycle (prev register), plus the wait for boundary.

Reset
REQ-038 On reset, the FSM SHALL go to IDLE and exc_enter, in_handler and take SHALL be 0.
REQ-039 On reset, exc_code and int_id SHALL be 0, the pending edge bits SHALL be 0, and prev SHALL be 0.
REQ-040 Because prev resets to 0, an edge line already high at reset release SHALL be latched as pending.
REQ-041 Reset asserted mid-handler SHALL abandon the handler with no exc_enter pulse.

Structure
REQ-042 The state encoding and exception-code constants (INT=0, SC=8, BP=9) SHALL reside in the shared package exc_pkg.
REQ-043 The priority encoder SHALL be the sub-module prio_enc, parametrised by N_INT and ID_W.

Verification
REQ-044 The bench SHALL cover: N_INT=6, EDGE_MASK=0, int_mask=6'h3F, int_en=1, hw_int=6'b000101, boundary pulse -> take=1, next cycle exc_enter=1, exc_code=0, int_id=2, then in_handler=1.
REQ-045 The bench SHALL cover: EDGE_MASK=6'h01, one-cycle pulse on hw_int[0], boundary=1 five cycles later -> take=1, int_id=0; pending[0] stays 1 until pend_clr[0]=1.
REQ-046 The bench SHALL cover: sync_req=1, sync_code=9 with a qualified interrupt on line 3 in the same cycle -> exc_code=9, int_id unchanged.
REQ-047 The bench SHALL cover: in HANDLER, a qualified interrupt plus boundary -> take=0; after eret -> IDLE next cycle, then take=1 at the next boundary.
REQ-048 The bench SHALL cover: edge set and pend_clr on the same line in the same cycle -> pending stays 1.
REQ-049 The bench SHALL cover: reset asserted in HANDLER with pending edge bits -> IDLE, pending=0, exc_code=0 immediately (asynchronous).
